// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: sequencer for a bit-serial adder with req/res valid-ready handshakes.
// Ports: clock/reset (async, active-high); req_valid/req_ready/req_a/req_b/req_cin accept operands;
// res_valid/res_ready/res_sum/res_cout return the captured result; busy is high outside IDLE;
// sa_load/sa_da/sa_db/sa_cin drive the adder, sa_sum/sa_cout come back from it.
// Build option SERIAL_ADD_CTRL_CHAIN_EN adds req_chain: take carry-in from the previous res_cout.
module serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_cin,
`ifdef SERIAL_ADD_CTRL_CHAIN_EN
  input  logic             req_chain,
`endif
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             busy,
  output logic             sa_load,
  output logic [WIDTH-1:0] sa_da,
  output logic [WIDTH-1:0] sa_db,
  output logic             sa_cin,
  input  logic [WIDTH-1:0] sa_sum,
  input  logic             sa_cout
);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, HOLD} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic cin_q, cin_d, cout_q, cout_d, cin_sel;
`ifdef SERIAL_ADD_CTRL_CHAIN_EN
  // res_cout holds the previous completed carry until the next capture, so it is the chain source
  assign cin_sel = req_chain ? cout_q : req_cin;
`else
  assign cin_sel = req_cin;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: if (req_valid) begin
        a_d     = req_a;
        b_d     = req_b;
        cin_d   = cin_sel;
        state_d = LOAD;
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          sum_d   = sa_sum;
          cout_d  = sa_cout;
          state_d = HOLD;
        end
      end
      HOLD: state_d = res_ready ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end
  assign req_ready = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign res_valid = state_q == HOLD;
  assign sa_load   = state_q == LOAD;
  assign sa_da     = a_q;
  assign sa_db     = b_q;
  assign sa_cin    = cin_q;
  assign res_sum   = sum_q;
  assign res_cout  = cout_q;
endmodule
